me_min_search: RTL and testbench
================================

# me_min_search

Responder side of the `req`/`ack` motion-estimation handshake. It accepts a request from a host controller, issues a one-cycle `start` to the SAD datapath, and consumes one SAD value per candidate position. It tracks the running minimum and its candidate index, then publishes `min_sad`/`min_mvec` with `ack` held under the four-phase protocol. It sits between the push-button/host request logic and the PE array's SAD output stream.

## Interface
- `TB_LENGTH`, 16, template block edge length in pixels
- `SW_LENGTH`, 64, search window edge length in pixels
- `PE_OUT_WIDTH`, 8, width of a single PE absolute-difference output
- derived `NUM_CAND` = (SW_LENGTH-TB_LENGTH+1)**2; `CNT_WIDTH` = $clog2(NUM_CAND); `SAD_WIDTH` = $clog2(TB_LENGTH**2)+PE_OUT_WIDTH

- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req`  in  1  request from initiator, level
- `sad_valid`  in  1  `sad_in` carries the next candidate's SAD
- `sad_in`  in  SAD_WIDTH  candidate SAD, unsigned
- `start`  out  1  one-cycle pulse telling the SAD datapath to begin streaming
- `busy`  out  1  high in RUN
- `min_sad`  out  SAD_WIDTH  minimum SAD of last completed search
- `min_mvec`  out  CNT_WIDTH  candidate index (0-based arrival order) of that minimum
- `ack`  out  1  result valid, four-phase acknowledge

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `ack`=0. `req`=1 -> RUN. On that edge: `cnt`<=0, `best_sad`<=all ones, `best_idx`<=0, `start`<=1.
- RUN: `start` high only in the first RUN cycle. Each cycle with `sad_valid`=1 is one candidate, including the start cycle.
  - If `sad_in` < `best_sad` (strict), `best_sad`<=`sad_in` and `best_idx`<=`cnt`. Ties keep the earlier index.
  - `cnt` increments on each accepted candidate.
- Completion: the accepted candidate with `cnt`==NUM_CAND-1 is included in the compare. On the same edge, the FSM goes to DONE, `min_sad`/`min_mvec` load the final minimum, and `ack`<=1.
- DONE: `ack` stays 1 while `req`=1. When `req`=0, the FSM returns to IDLE and `ack`<=0 on the same edge.
- Abort: if `req`=0 in RUN, the FSM returns to IDLE next edge. `ack` is never asserted. `min_sad`/`min_mvec` keep the previous completed result. Any `sad_valid` in the abort cycle is ignored.
- `sad_valid` in IDLE/DONE is ignored. `cnt` never exceeds NUM_CAND-1.
- Output registers change only on completion or reset. Working registers (`best_sad`, `best_idx`, `cnt`) are internal.
- Reset (`rst_n`=0 at an edge): FSM to IDLE; `start`, `busy`, `ack`, `min_sad`, `min_mvec` all 0; working registers 0. Reset overrides all other events, including mid-RUN and DONE.

## Timing
- `req` rises at edge N-sample -> `start`=1, `busy`=1 during cycle N+1.
- Latency from the last accepted `sad_valid` to `ack`=1 is one edge. Result outputs are valid in the same cycle `ack` rises.
- `req` low sampled in DONE -> `ack`=0 one edge later.
- A new request cannot start until `ack` has been seen low (IDLE). `req` held high through DONE does not restart.
- Minimum full transaction: 1 (IDLE->RUN) + NUM_CAND accepted cycles; back-to-back `sad_valid` at full rate is supported.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
Small config unless noted: TB_LENGTH=2, SW_LENGTH=3 -> NUM_CAND=4, CNT_WIDTH=2, SAD_WIDTH=10.

- Basic: `req`=1, then SADs 40,12,30,25 back-to-back -> `start` for one cycle, `ack`=1 one edge after the 4th, `min_sad`=12, `min_mvec`=1. Drop `req` -> `ack`=0 next edge.
- Tie and bubbles: SADs 7,9,7,7 with idle gaps between `sad_valid` pulses -> `min_sad`=7, `min_mvec`=0, `ack` only after the 4th valid.
- Extremes: SADs 1023,1023,1023,0 -> `min_sad`=0, `min_mvec`=3. A second run with all 1023 -> `min_sad`=1023, `min_mvec`=0.
- Abort: after a completed run (`min_sad`=12), a new `req`, two SADs (5,3), then `req`=0 -> IDLE, `ack` stays 0, `min_sad` stays 12, `min_mvec` stays 1. The next full run then works normally.
- Reset: assert `rst_n`=0 mid-RUN and separately in DONE -> next edge all outputs 0, FSM IDLE, `start` not re-issued until `req` is seen high again after release.
- Default params: 2401 random SADs with the minimum 17 at index 2400 -> `min_mvec`=2400 (12 bits), `min_sad`=17. `sad_valid` pulses with `req` low -> no state change.

Source files
------------

// File: rtl/me_min_search.sv
// Minimum-SAD search responder: accepts a four-phase req/ack request, kicks the
// SAD datapath with a one-cycle start, and tracks the best candidate index.
module me_min_search #(
  parameter int TB_LENGTH    = 16,
  parameter int SW_LENGTH    = 64,
  parameter int PE_OUT_WIDTH = 8,
  localparam int NUM_CAND    = (SW_LENGTH - TB_LENGTH + 1) ** 2,
  localparam int CNT_WIDTH   = $clog2(NUM_CAND),
  localparam int SAD_WIDTH   = $clog2(TB_LENGTH ** 2) + PE_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic                 sad_valid,
  input  logic [SAD_WIDTH-1:0] sad_in,
  output logic                 start,
  output logic                 busy,
  output logic [SAD_WIDTH-1:0] min_sad,
  output logic [CNT_WIDTH-1:0] min_mvec,
  output logic                 ack
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_CAND - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [SAD_WIDTH-1:0]   best_sad;
  logic [CNT_WIDTH-1:0]   best_idx;
  logic [SAD_WIDTH-1:0]   cand_sad;
  logic [CNT_WIDTH-1:0]   cand_idx;

  // Running minimum including the current candidate; strict compare keeps
  // the earliest index on ties.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    cand_sad = best_sad;
    cand_idx = best_idx;
    if (sad_in < best_sad) begin
      cand_sad = sad_in;
      cand_idx = cnt;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      best_sad <= '0;
      best_idx <= '0;
      start    <= 1'b0;
      busy     <= 1'b0;
      ack      <= 1'b0;
      min_sad  <= '0;
      min_mvec <= '0;
    end else begin
      start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            state    <= RUN;
            cnt      <= '0;
            best_sad <= '1;
            best_idx <= '0;
            start    <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (!req) begin
            // Abort: drop the partial search, published result is untouched.
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sad_valid) begin
            best_sad <= cand_sad;
            best_idx <= cand_idx;
            if (cnt == LAST_CNT) begin
              state    <= DONE;
              busy     <= 1'b0;
              min_sad  <= cand_sad;
              min_mvec <= cand_idx;
              ack      <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (!req) begin
            state <= IDLE;
            ack   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_min_search.sv
// Directed bench: small config (4 candidates) table-driven plus abort/reset
// sequences, and one full-size default-config search.
module tb_me_min_search;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Small configuration: NUM_CAND=4, CNT_WIDTH=2, SAD_WIDTH=10
  logic       req_s, sad_valid_s, start_s, busy_s, ack_s;
  logic [9:0] sad_in_s, min_sad_s;
  logic [1:0] min_mvec_s;

  // Default configuration: NUM_CAND=2401, CNT_WIDTH=12, SAD_WIDTH=16
  logic        req_b, sad_valid_b, start_b, busy_b, ack_b;
  logic [15:0] sad_in_b, min_sad_b;
  logic [11:0] min_mvec_b;

  me_min_search #(.TB_LENGTH(2), .SW_LENGTH(3), .PE_OUT_WIDTH(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .req(req_s), .sad_valid(sad_valid_s),
    .sad_in(sad_in_s), .start(start_s), .busy(busy_s),
    .min_sad(min_sad_s), .min_mvec(min_mvec_s), .ack(ack_s)
  );

  me_min_search dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .sad_valid(sad_valid_b),
    .sad_in(sad_in_b), .start(start_b), .busy(busy_b),
    .min_sad(min_sad_b), .min_mvec(min_mvec_b), .ack(ack_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    string           name;
    logic [3:0][9:0] sad;
    int              gap;
    logic [9:0]      exp_sad;
    logic [1:0]      exp_idx;
  } vec_t;

  // One complete small-config transaction, checked cycle by cycle.
  task automatic run_small(input vec_t v);
    @(negedge clk);
    req_s = 1'b1; sad_valid_s = 1'b0;
    @(negedge clk);
    check({v.name, ".start"}, 32'(start_s), 1);
    check({v.name, ".busy"},  32'(busy_s),  1);
    check({v.name, ".ack0"},  32'(ack_s),   0);
    for (int i = 0; i < 4; i++) begin
      sad_valid_s = 1'b1;
      sad_in_s    = v.sad[i];
      @(negedge clk);
      sad_valid_s = 1'b0;
      sad_in_s    = 10'h3ff;
      if (i == 0) check({v.name, ".start_once"}, 32'(start_s), 0);
      if (i < 3) begin
        check({v.name, ".ack_early"}, 32'(ack_s), 0);
        repeat (v.gap) @(negedge clk);
        if (v.gap > 0) check({v.name, ".ack_gap"}, 32'(ack_s), 0);
      end
    end
    check({v.name, ".ack"},      32'(ack_s),      1);
    check({v.name, ".busy_end"}, 32'(busy_s),     0);
    check({v.name, ".min_sad"},  32'(min_sad_s),  32'(v.exp_sad));
    check({v.name, ".min_mvec"}, 32'(min_mvec_s), 32'(v.exp_idx));
    // req held high in DONE: ack holds, no restart
    @(negedge clk);
    check({v.name, ".ack_hold"},  32'(ack_s),   1);
    check({v.name, ".no_restart"}, 32'(start_s), 0);
    req_s = 1'b0;
    @(negedge clk);
    check({v.name, ".ack_drop"}, 32'(ack_s), 0);
    check({v.name, ".min_keep"}, 32'(min_sad_s), 32'(v.exp_sad));
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"basic",   {10'd25,   10'd30,   10'd12,   10'd40},   0, 10'd12,   2'd1};
    vecs[1] = '{"tie_gap", {10'd7,    10'd7,    10'd9,    10'd7},    2, 10'd7,    2'd0};
    vecs[2] = '{"ext_min", {10'd0,    10'd1023, 10'd1023, 10'd1023}, 0, 10'd0,    2'd3};
    vecs[3] = '{"all_max", {10'd1023, 10'd1023, 10'd1023, 10'd1023}, 1, 10'd1023, 2'd0};
    vecs[4] = '{"descend", {10'd2,    10'd3,    10'd4,    10'd5},    0, 10'd2,    2'd3};
    vecs[5] = '{"mid_min", {10'd9,    10'd1,    10'd8,    10'd6},    3, 10'd1,    2'd2};

    rst_n = 1'b0;
    req_s = 1'b0; sad_valid_s = 1'b0; sad_in_s = '0;
    req_b = 1'b0; sad_valid_b = 1'b0; sad_in_b = '0;
    repeat (2) @(negedge clk);
    check("rst.start",    32'(start_s),    0);
    check("rst.busy",     32'(busy_s),     0);
    check("rst.ack",      32'(ack_s),      0);
    check("rst.min_sad",  32'(min_sad_s),  0);
    check("rst.min_mvec", 32'(min_mvec_s), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_small(vecs[i]);

    // Abort after a completed basic run
    run_small(vecs[0]);
    @(negedge clk);
    req_s = 1'b1;
    @(negedge clk);
    sad_valid_s = 1'b1; sad_in_s = 10'd5;
    @(negedge clk);
    sad_in_s = 10'd3;
    @(negedge clk);
    req_s = 1'b0; sad_in_s = 10'd0;
    @(negedge clk);
    sad_valid_s = 1'b0;
    check("abort.busy",     32'(busy_s),     0);
    check("abort.ack",      32'(ack_s),      0);
    check("abort.min_sad",  32'(min_sad_s),  12);
    check("abort.min_mvec", 32'(min_mvec_s), 1);
    @(negedge clk);
    check("abort.idle_start", 32'(start_s), 0);
    check("abort.idle_ack",   32'(ack_s),   0);
    run_small(vecs[5]);

    // Reset mid-RUN
    @(negedge clk);
    req_s = 1'b1;
    @(negedge clk);
    sad_valid_s = 1'b1; sad_in_s = 10'd4;
    @(negedge clk);
    sad_valid_s = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rstrun.busy",     32'(busy_s),     0);
    check("rstrun.start",    32'(start_s),    0);
    check("rstrun.ack",      32'(ack_s),      0);
    check("rstrun.min_sad",  32'(min_sad_s),  0);
    check("rstrun.min_mvec", 32'(min_mvec_s), 0);
    req_s = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rstrun.no_start", 32'(start_s), 0);
    check("rstrun.idle",     32'(busy_s),  0);
    run_small(vecs[0]);

    // Reset in DONE
    @(negedge clk);
    req_s = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sad_valid_s = 1'b1; sad_in_s = 10'(50 + 10 * i);
      @(negedge clk);
    end
    sad_valid_s = 1'b0;
    check("rstdone.ack_pre", 32'(ack_s),     1);
    check("rstdone.min_pre", 32'(min_sad_s), 50);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstdone.ack",      32'(ack_s),      0);
    check("rstdone.min_sad",  32'(min_sad_s),  0);
    check("rstdone.min_mvec", 32'(min_mvec_s), 0);
    req_s = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rstdone.no_start", 32'(start_s), 0);
    run_small(vecs[2]);

    // Default config: sad_valid with req low is ignored
    sad_valid_b = 1'b1; sad_in_b = 16'd0;
    repeat (3) @(negedge clk);
    sad_valid_b = 1'b0;
    check("big.idle_busy",  32'(busy_b),    0);
    check("big.idle_start", 32'(start_b),   0);
    check("big.idle_ack",   32'(ack_b),     0);
    check("big.idle_min",   32'(min_sad_b), 0);

    req_b = 1'b1;
    @(negedge clk);
    check("big.start", 32'(start_b), 1);
    for (int i = 0; i < 2401; i++) begin
      sad_valid_b = 1'b1;
      sad_in_b    = (i == 2400) ? 16'd17 : 16'($urandom_range(18, 65535));
      @(negedge clk);
      if (i == 2399) check("big.ack_early", 32'(ack_b), 0);
    end
    sad_valid_b = 1'b0;
    check("big.ack",      32'(ack_b),      1);
    check("big.min_sad",  32'(min_sad_b),  17);
    check("big.min_mvec", 32'(min_mvec_b), 2400);
    req_b = 1'b0;
    @(negedge clk);
    check("big.ack_drop", 32'(ack_b), 0);
    sad_valid_b = 1'b1; sad_in_b = 16'd1;
    repeat (3) @(negedge clk);
    sad_valid_b = 1'b0;
    check("big.post_busy",     32'(busy_b),     0);
    check("big.post_min_sad",  32'(min_sad_b),  17);
    check("big.post_min_mvec", 32'(min_mvec_b), 2400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
